mem_access_stage: RTL
=====================

# mem_access_stage

Pipeline MEM stage of the 5-stage MIPS core. Sits directly downstream of the EX/MEM pipeline register. It consumes MEM_M, WB_M, ALUOut_M, WriteData_M and WriteReg_M. It performs word loads/stores to data memory over a req/ack handshake, stalls the front of the pipeline while an access is outstanding, and drives the registered MEM/WB outputs for writeback.

## Interface
Parameters:
- ACK_TIMEOUT, 16: max BUSY cycles waiting for dmem_ack before abort (1..255).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- MEM_M  in  3  {Branch, MemRead, MemWrite}; bits 2/1/0. Branch is ignored here.
- WB_M  in  2  {RegWrite, MemtoReg}.
- ALUOut_M  in  32  byte address for memory ops; result for ALU ops.
- WriteData_M  in  32  store data.
- WriteReg_M  in  5  destination register.
- stall_M  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM while high.
- dmem_req  out  1  registered access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_addr  out  32  word-aligned byte address; valid while dmem_req.
- dmem_wdata  out  32  store data; valid while dmem_req.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  load data; valid in the dmem_ack cycle.
- WB_W  out  2  registered WB control.
- ReadData_W  out  32  registered load data.
- ALUOut_W  out  32  registered ALU result.
- WriteReg_W  out  5  registered destination register.
- bus_err_W  out  1  registered one-cycle pulse: access aborted on timeout.

## Operation
- Memory op (mem_op) = MemRead | MemWrite. If both bits are set, treat it as a store.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no mem_op: MEM/WB register loads the inputs next edge. stall_M=0. Zero added latency.
- IDLE, mem_op: stall_M=1. Latch address, data and we into the request registers. Go to BUSY. MEM/WB loads a bubble (WB_W=0).
- BUSY: dmem_req=1 with addr/wdata/we held stable. stall_M=1. The timeout counter increments each cycle. MEM/WB loads a bubble.
  - On dmem_ack: capture dmem_rdata, drop dmem_req next edge, go to DONE.
  - When the counter reaches ACK_TIMEOUT with no ack: drop dmem_req, pulse bus_err_W, go to DONE with RegWrite suppressed.
- DONE: stall_M=0. MEM/WB loads WB_M (RegWrite forced 0 after a timeout), captured ReadData, ALUOut_M and WriteReg_M. Go to IDLE.
- The EX/MEM inputs are frozen by stall_M, so they stay valid through BUSY and DONE.
- A dmem_ack received outside BUSY is ignored.
- Reset values: state=IDLE, counter=0, and all outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, WB_W, ReadData_W, ALUOut_W, WriteReg_W, bus_err_W. stall_M evaluates to 0.
- Reset during BUSY abandons the access: dmem_req=0 after the reset edge. Data memory tolerates a dropped request.

## Timing
- Non-memory op: MEM→WB in 1 cycle.
- Memory op with ack in the first BUSY cycle: 3 cycles in MEM (IDLE, BUSY, DONE), i.e. stall_M high for 2 cycles.
- Each extra wait cycle adds 1 cycle.
- Timeout: abort after ACK_TIMEOUT BUSY cycles. bus_err_W is high in the cycle after the abort edge.
- A store completes on ack. ReadData_W is don't-care for stores, and the implementation registers 0.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A mem_op with ALUOut_M[1:0]≠0 issues no request and does not stall.
  - MEM/WB loads with RegWrite=0.
  - A registered output misalign_W (1 bit, reset 0) pulses for one cycle.
- MEM_ALIGN_CHECK_EN undefined:
  - No misalign_W port.
  - dmem_addr = {ALUOut_M[31:2], 2'b00}; low bits are silently dropped.

## Structure
- Shared package mem_stage_pkg contains:
  - state enum (IDLE/BUSY/DONE);
  - MEM_M bit indices (MEM_BRANCH=2, MEM_READ=1, MEM_WRITE=0);
  - WB bit indices (WB_REGWRITE=1, WB_MEMTOREG=0).
- One sub-module, mem_wb_reg: a plain MEM/WB pipeline register with a synchronous active-low reset and a bubble input that zeros WB.

## Test plan
- ALU op, WB_M=2'b10, ALUOut_M=0x1234 → next cycle WB_W=2'b10, ALUOut_W=0x1234; stall_M never high.
- Load, address 0x40, ack after 1 cycle with rdata=0xDEADBEEF → stall_M high for 2 cycles; dmem_we=0; ReadData_W=0xDEADBEEF and WB_W=WB_M in the DONE+1 cycle.
- Store, address 0x80, wdata 0xCAFEF00D, ack delayed 5 cycles → dmem_addr/wdata stable for all 5 BUSY cycles; stall_M high for 6 cycles.
- ACK_TIMEOUT=4, no ack → dmem_req drops after 4 cycles; bus_err_W pulses once; WB_W[1]=0.
- rst_n low during BUSY → dmem_req=0, state IDLE, and all outputs 0 after the edge. A late ack is ignored.
- With MEM_ALIGN_CHECK_EN, load at 0x41 → no dmem_req; misalign_W pulses; WB_W[1]=0; stall_M=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and bit indices for the MIPS MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MEM_BRANCH  = 2;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register; bubble zeros the WB control field.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic [1:0]  wb_in,
  input  logic [31:0] read_data_in,
  input  logic [31:0] alu_out_in,
  input  logic [4:0]  write_reg_in,
  output logic [1:0]  wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_out_out,
  output logic [4:0]  write_reg_out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_out        <= 2'b00;
      read_data_out <= 32'd0;
      alu_out_out   <= 32'd0;
      write_reg_out <= 5'd0;
    end else begin
      wb_out        <= bubble ? 2'b00 : wb_in;
      read_data_out <= read_data_in;
      alu_out_out   <= alu_out_in;
      write_reg_out <= write_reg_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MIPS MEM stage; word load/store over req/ack with timeout.
//               Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  MEM_M,
  input  logic [1:0]  WB_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] WriteData_M,
  input  logic [4:0]  WriteReg_M,
  output logic        stall_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  WB_W,
  output logic [31:0] ReadData_W,
  output logic [31:0] ALUOut_W,
  output logic [4:0]  WriteReg_W,
  output logic        bus_err_W
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_W
`endif
);

  import mem_stage_pkg::*;

  localparam logic [7:0] C_TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_count;
  logic        r_timed_out;
  logic [31:0] r_rdata;

  logic        w_mem_op;
  logic        w_is_store;
  logic        w_misaligned;
  logic        w_issue;
  logic        w_timeout;
  logic        w_bubble;
  logic [1:0]  w_wb;
  logic [31:0] w_read_data;
  logic        w_unused_branch;

  assign w_unused_branch = MEM_M[MEM_BRANCH];
  assign w_mem_op        = MEM_M[MEM_READ] | MEM_M[MEM_WRITE];
  assign w_is_store      = MEM_M[MEM_WRITE];
`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned    = w_mem_op & (ALUOut_M[1:0] != 2'b00);
`else
  assign w_misaligned    = 1'b0;
`endif
  assign w_issue         = w_mem_op & ~w_misaligned;
  // An ack in the same cycle as the last allowed wait wins over the abort.
  assign w_timeout       = (r_state == BUSY) & ~dmem_ack & (r_count == C_TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next_state = BUSY;
      BUSY:    if (dmem_ack || w_timeout) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    stall_M     = 1'b0;
    w_bubble    = 1'b0;
    w_wb        = WB_M;
    w_read_data = 32'd0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          stall_M  = w_issue;
          w_bubble = w_issue;
          if (w_misaligned) w_wb[WB_REGWRITE] = 1'b0;
        end
        BUSY: begin
          stall_M  = 1'b1;
          w_bubble = 1'b1;
        end
        DONE: begin
          w_read_data = r_rdata;
          if (r_timed_out) w_wb[WB_REGWRITE] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_wdata  <= 32'd0;
      r_count     <= 8'd0;
      r_rdata     <= 32'd0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            dmem_req    <= 1'b1;
            dmem_we     <= w_is_store;
            dmem_addr   <= {ALUOut_M[31:2], 2'b00};
            dmem_wdata  <= WriteData_M;
            r_count     <= 8'd0;
            r_rdata     <= 32'd0;
            r_timed_out <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            r_rdata  <= dmem_we ? 32'd0 : dmem_rdata;
          end else if (w_timeout) begin
            dmem_req    <= 1'b0;
            r_timed_out <= 1'b1;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bus_err_W <= 1'b0;
    else        bus_err_W <= w_timeout;
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_W <= 1'b0;
    else        misalign_W <= (r_state == IDLE) & w_misaligned;
  end
`endif

  mem_wb_reg u_mem_wb_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .bubble        (w_bubble),
    .wb_in         (w_wb),
    .read_data_in  (w_read_data),
    .alu_out_in    (ALUOut_M),
    .write_reg_in  (WriteReg_M),
    .wb_out        (WB_W),
    .read_data_out (ReadData_W),
    .alu_out_out   (ALUOut_W),
    .write_reg_out (WriteReg_W)
  );

endmodule
`default_nettype wire
